// File: rtl/mips_pkg.sv
// Shared definitions for the iterative shifter: op encodings and FSM state type.
// Pure declarations, no logic.
// Imported by shift_unit_if users, shift_step and shift_unit.
package mips_pkg;

  // Operation encodings as seen on in_op
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_t;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int OP_W = 2;

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between a requester (master) and shift_unit (slave).
// No logic; carries the valid/ready request channel, result channel and busy.
// Backpressure: in_ready gates requests, out_ready holds the result.
interface shift_unit_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits for SLL/SRL/SRA (and ROTR when
// SHIFT_UNIT_ROTATE_EN is defined; otherwise op 11 behaves as SRL).
// Latency 0, no backpressure (pure combinational).
module shift_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [AW-1:0]    i_amt,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_data
);

`ifdef SHIFT_UNIT_ROTATE_EN
  logic [2*WIDTH-1:0] w_dbl;

  // Rotate by shifting a doubled copy; the low half is the rotated word
  always_comb begin
    w_dbl = {i_data, i_data} >> i_amt;
  end
`endif

  // Select the shift flavour; the partially shifted word keeps the original MSB
  // for SRA, so arithmetic shift of the current word replicates it correctly
  always_comb begin
    o_data = i_data >> i_amt;
    case (i_op)
      OP_SLL:  o_data = i_data << i_amt;
      OP_SRA:  o_data = $signed(i_data) >>> i_amt;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROTR: o_data = w_dbl[WIDTH-1:0];
`endif
      default: o_data = i_data >> i_amt;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle barrel-shift replacement: up to STEP bits per clock (SHIFT_UNIT_ROTATE_EN enables ROTR).
// Latency: max(1, ceil(shamt/STEP)) clocks from accept to out_valid.
// Backpressure: one request in flight; result held in DONE until out_ready.
module shift_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  shift_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int AW  = $clog2(STEP + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_rem;
  op_t              r_op;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_src_data;
  logic [SHW-1:0]   w_src_rem;
  op_t              w_src_op;
  logic [AW-1:0]    w_amt;
  logic [SHW-1:0]   w_rem_next;
  logic [WIDTH-1:0] w_res;

  // The single shift_step is shared: in IDLE it works on the incoming request so
  // the accept edge already performs the first step, afterwards on the registers
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_src_data = bus.in_data;
      w_src_rem  = bus.in_shamt;
      w_src_op   = op_t'(bus.in_op);
    end else begin
      w_src_data = r_data;
      w_src_rem  = r_rem;
      w_src_op   = r_op;
    end
  end

  // Step size is min(remaining, STEP); when STEP == WIDTH the remaining count
  // always wins, so the narrowing cast of w_amt below never loses bits
  always_comb begin
    if ({{(32-SHW){1'b0}}, w_src_rem} >= 32'(STEP)) begin
      w_amt = AW'(STEP);
    end else begin
      w_amt = AW'(w_src_rem);
    end
    w_rem_next = w_src_rem - SHW'(w_amt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data (w_src_data),
    .i_amt  (w_amt),
    .i_op   (w_src_op),
    .o_data (w_res)
  );

  // Control FSM with registered handshake outputs; reset beats any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_rem       <= '0;
      r_op        <= OP_SLL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_data     <= w_res;
            r_rem      <= w_rem_next;
            r_op       <= op_t'(bus.in_op);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_rem_next == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_res;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rem       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.busy      = r_busy;

endmodule
